// File: rtl/write_pattern_gen.sv
// Multi-mode write-pattern generator: on a synchronised start edge it emits a burst of
// addressed write words (increment, inverted, walking-one or LFSR) with back-pressure and abort.
module write_pattern_gen #(
  parameter int                    ADDR_WIDTH    = 14,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    PATTERN_COUNT = 100,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE     = '0,
  parameter logic                  WE_POLARITY   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY     = DATA_WIDTH'(32'h8020_0003),
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED     = DATA_WIDTH'(32'h0000_0001)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic [1:0]            mode_in,
  input  logic [ADDR_WIDTH:0]   len_in,
  input  logic                  ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  start_out,
  output logic                  end_out,
  output logic                  aborted,
  output logic                  busy
);

  // Handshake: a word is transferred on a rising clk edge when we is at its
  // active level and ready is 1; while ready is 0 we/addr/data hold unchanged.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEF_LEN  = (ADDR_WIDTH+1)'(PATTERN_COUNT);
  localparam logic                WE_IDLE  = ~WE_POLARITY;

  state_t                  state_q, state_d;
  logic                    s1_q, s2_q;
  logic [1:0]              mode_q, mode_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    start_out_q, start_out_d;
  logic                    end_q, end_d;
  logic                    abort_q, abort_d;
  logic                    busy_q, busy_d;

  logic                    start_edge, start_fall;
  logic                    presenting, accept, last_accept;
  logic [ADDR_WIDTH:0]     idx_inc;
  logic [DATA_WIDTH-1:0]   lfsr_adv;

  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern_word(
    input logic [1:0]            m,
    input logic [ADDR_WIDTH:0]   i,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] iw;
    logic [31:0]           i32;
    iw  = DATA_WIDTH'(i);
    i32 = 32'(i);
    case (m)
      2'd0:    pattern_word = iw;
      2'd1:    pattern_word = ~iw;
      2'd2:    pattern_word = DATA_WIDTH'(1) << (i32 % 32'(DATA_WIDTH));
      default: pattern_word = s;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH:0] i);
    word_addr = ADDR_BASE + i[ADDR_WIDTH-1:0];
  endfunction

  assign start_edge  = s1_q & ~s2_q;
  assign start_fall  = ~s1_q & s2_q;
  assign presenting  = (we_q == WE_POLARITY);
  assign accept      = presenting & ready;
  assign last_accept = accept & (idx_q == (len_q - IDX_ONE));
  assign idx_inc     = idx_q + IDX_ONE;
  assign lfsr_adv    = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      mode_q      <= 2'd0;
      len_q       <= '0;
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      we_q        <= WE_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      start_out_q <= 1'b0;
      end_q       <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= start_in;
      s2_q        <= s1_q;
      mode_q      <= mode_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      start_out_q <= start_out_d;
      end_q       <= end_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    start_out_d = start_out_q;
    end_d       = end_q;
    abort_d     = abort_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          mode_d      = mode_in;
          len_d       = (len_in == '0) ? DEF_LEN : len_in;
          idx_d       = '0;
          lfsr_d      = LFSR_SEED;
          start_out_d = 1'b0;
          end_d       = 1'b0;
          abort_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Normal completion has priority over a fall seen in the same cycle.
        if (last_accept) begin
          we_d    = WE_IDLE;
          end_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (start_fall) begin
          we_d    = WE_IDLE;
          abort_d = 1'b1;
          end_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!presenting) begin
          we_d        = WE_POLARITY;
          addr_d      = word_addr(idx_q);
          data_d      = pattern_word(mode_q, idx_q, lfsr_q);
          start_out_d = 1'b1;
        end else if (accept) begin
          idx_d  = idx_inc;
          lfsr_d = lfsr_adv;
          we_d   = WE_POLARITY;
          addr_d = word_addr(idx_inc);
          data_d = pattern_word(mode_q, idx_inc, lfsr_adv);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign start_out = start_out_q;
  assign end_out   = end_q;
  assign aborted   = abort_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_write_pattern_gen.sv
// Scoreboard bench for write_pattern_gen: three instances (default, 4-bit address with
// active-low we, 2-bit data at a wrapping base address) driven by directed bursts.
module tb_write_pattern_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u0: default parameters
  logic        start0, ready0, we0, start_out0, end0, aborted0, busy0;
  logic [1:0]  mode0;
  logic [14:0] len0;
  logic [13:0] addr0;
  logic [31:0] data0;
  // u1: 4-bit address, active-low we
  logic        start1, ready1, we1, start_out1, end1, aborted1, busy1;
  logic [1:0]  mode1;
  logic [4:0]  len1;
  logic [3:0]  addr1;
  logic [31:0] data1;
  // u2: 2-bit data, base address near the top of the space
  logic        start2, ready2, we2, start_out2, end2, aborted2, busy2;
  logic [1:0]  mode2;
  logic [14:0] len2;
  logic [13:0] addr2;
  logic [1:0]  data2;

  write_pattern_gen u0 (
    .clk(clk), .reset(reset), .start_in(start0), .mode_in(mode0), .len_in(len0),
    .ready(ready0), .we(we0), .addr(addr0), .data(data0), .start_out(start_out0),
    .end_out(end0), .aborted(aborted0), .busy(busy0)
  );

  write_pattern_gen #(.ADDR_WIDTH(4), .WE_POLARITY(1'b0)) u1 (
    .clk(clk), .reset(reset), .start_in(start1), .mode_in(mode1), .len_in(len1),
    .ready(ready1), .we(we1), .addr(addr1), .data(data1), .start_out(start_out1),
    .end_out(end1), .aborted(aborted1), .busy(busy1)
  );

  write_pattern_gen #(.DATA_WIDTH(2), .ADDR_BASE(14'h3FFE), .LFSR_POLY(2'b11),
                      .LFSR_SEED(2'b01)) u2 (
    .clk(clk), .reset(reset), .start_in(start2), .mode_in(mode2), .len_in(len2),
    .ready(ready2), .we(we2), .addr(addr2), .data(data2), .start_out(start_out2),
    .end_out(end2), .aborted(aborted2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  logic [45:0] exp_q0[$];
  logic [35:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int which, input int max_cycles);
    logic done;
    int   n;
    done = 1'b0;
    n = 0;
    while (!done && n < max_cycles) begin
      ticks(1);
      n++;
      case (which)
        0:       done = end0 | aborted0;
        1:       done = end1 | aborted1;
        default: done = end2 | aborted2;
      endcase
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: no end/abort within %0d cycles", which, max_cycles);
    end
  endtask

  // Monitor: every write the DUT will accept at the coming edge is matched against the queue.
  always @(negedge clk) begin
    if (reset && we0 == 1'b1 && ready0) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0 extra write: addr %0h data %0h, none expected", addr0, data0);
      end else chk("sb0 write", {18'd0, addr0, data0}, {18'd0, exp_q0.pop_front()});
    end
    if (reset && we1 == 1'b0 && ready1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1 extra write: addr %0h data %0h, none expected", addr1, data1);
      end else chk("sb1 write", {28'd0, addr1, data1}, {28'd0, exp_q1.pop_front()});
    end
    if (reset && we2 == 1'b1 && ready2) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb2 extra write: addr %0h data %0h, none expected", addr2, data2);
      end else chk("sb2 write", {48'd0, addr2, data2}, {48'd0, exp_q2.pop_front()});
    end
  end

  initial begin
    reset = 1'b0;
    start0 = 0; mode0 = 0; len0 = 0; ready0 = 1;
    start1 = 0; mode1 = 0; len1 = 0; ready1 = 1;
    start2 = 0; mode2 = 0; len2 = 0; ready2 = 1;

    // Reset state
    ticks(2);
    chk("rst we0", we0, 0);
    chk("rst addr0", addr0, 0);
    chk("rst data0", data0, 0);
    chk("rst flags0", {start_out0, end0, aborted0, busy0}, 0);
    chk("rst we1 inactive high", we1, 1);
    chk("rst we2", we2, 0);
    reset = 1'b1;
    ticks(1);

    // Increment, default length; mode/len changes mid-burst must be ignored
    for (int i = 0; i < 100; i++) exp_q0.push_back({14'(i), 32'(i)});
    start0 = 1;
    ticks(2);
    chk("inc busy after start", busy0, 1);
    chk("inc we before 3rd edge", we0, 0);
    ticks(1);
    chk("inc we at 3rd edge", we0, 1);
    chk("inc start_out", start_out0, 1);
    chk("inc first addr", addr0, 0);
    mode0 = 2'd1; len0 = 15'd5;
    ticks(99);
    chk("inc last word addr", addr0, 99);
    chk("inc end before last accept", end0, 0);
    ticks(1);
    chk("inc end_out at 103", end0, 1);
    chk("inc busy cleared", busy0, 0);
    chk("inc we off", we0, 0);
    chk("inc start_out held", start_out0, 1);
    chk("inc queue drained", exp_q0.size(), 0);
    start0 = 0; mode0 = 0; len0 = 0;
    ticks(3);

    // LFSR mode with a two-cycle stall on the second word
    mode0 = 2'd3; len0 = 15'd3;
    exp_q0.push_back({14'd0, 32'h0000_0001});
    exp_q0.push_back({14'd1, 32'h8020_0003});
    exp_q0.push_back({14'd2, 32'hC030_0002});
    start0 = 1;
    ticks(2);
    chk("lfsr start_out cleared", start_out0, 0);
    chk("lfsr end_out cleared", end0, 0);
    ticks(2);
    ready0 = 0;
    chk("lfsr word1 data", data0, 32'h8020_0003);
    ticks(2);
    chk("lfsr stall we held", we0, 1);
    chk("lfsr stall addr held", addr0, 1);
    chk("lfsr stall data held", data0, 32'h8020_0003);
    ready0 = 1;
    wait_done(0, 20);
    chk("lfsr end_out", end0, 1);
    chk("lfsr not aborted", aborted0, 0);
    chk("lfsr exactly 3 writes", exp_q0.size(), 0);
    start0 = 0;
    ticks(3);

    // Walking one: 32-bit at base 0, 2-bit at base 0x3FFE (address wraps)
    mode0 = 2'd2; len0 = 15'd4; mode2 = 2'd2; len2 = 15'd4;
    exp_q0.push_back({14'd0, 32'h1}); exp_q0.push_back({14'd1, 32'h2});
    exp_q0.push_back({14'd2, 32'h4}); exp_q0.push_back({14'd3, 32'h8});
    exp_q2.push_back({14'h3FFE, 2'h1}); exp_q2.push_back({14'h3FFF, 2'h2});
    exp_q2.push_back({14'h0000, 2'h1}); exp_q2.push_back({14'h0001, 2'h2});
    start0 = 1; start2 = 1;
    ticks(3);
    chk("walk2 first addr", addr2, 14'h3FFE);
    chk("walk2 first data", data2, 2'h1);
    wait_done(0, 20);
    wait_done(2, 20);
    chk("walk0 end_out", end0, 1);
    chk("walk2 end_out", end2, 1);
    chk("walk0 queue drained", exp_q0.size(), 0);
    chk("walk2 queue drained", exp_q2.size(), 0);
    start0 = 0; start2 = 0;
    ticks(3);

    // Fall coinciding with last-word acceptance: completion wins
    mode0 = 2'd0; len0 = 15'd3;
    for (int i = 0; i < 3; i++) exp_q0.push_back({14'(i), 32'(i)});
    start0 = 1;
    ticks(4);
    start0 = 0;
    ticks(2);
    chk("coincide end_out", end0, 1);
    chk("coincide aborted", aborted0, 0);
    chk("coincide busy", busy0, 0);
    chk("coincide queue drained", exp_q0.size(), 0);
    ticks(3);

    // Abort after 10 accepted words; two more are accepted during sync latency
    mode0 = 2'd0; len0 = 15'd0;
    for (int i = 0; i < 12; i++) exp_q0.push_back({14'(i), 32'(i)});
    start0 = 1;
    ticks(13);
    start0 = 0;
    ticks(1);
    chk("abort we still on", we0, 1);
    chk("abort not yet flagged", aborted0, 0);
    ticks(1);
    chk("abort we off", we0, 0);
    chk("abort aborted", aborted0, 1);
    chk("abort end_out", end0, 0);
    chk("abort busy", busy0, 0);
    chk("abort 12 writes", exp_q0.size(), 0);
    ticks(2);
    len0 = 15'd2;
    exp_q0.push_back({14'd0, 32'd0}); exp_q0.push_back({14'd1, 32'd1});
    start0 = 1;
    ticks(2);
    chk("restart aborted cleared", aborted0, 0);
    chk("restart busy", busy0, 1);
    ticks(1);
    chk("restart addr base", addr0, 0);
    wait_done(0, 10);
    chk("restart end_out", end0, 1);
    chk("restart queue drained", exp_q0.size(), 0);
    start0 = 0;
    ticks(3);

    // Reset in the middle of a stalled burst
    len0 = 15'd0; ready0 = 0;
    start0 = 1;
    ticks(5);
    chk("midrst we presented", we0, 1);
    reset = 0;
    ticks(1);
    chk("midrst we off", we0, 0);
    chk("midrst busy", busy0, 0);
    chk("midrst addr", addr0, 0);
    start0 = 0;
    ticks(1);
    reset = 1; ready0 = 1;
    ticks(3);

    // Full depth, inverted mode, active-low we
    mode1 = 2'd1; len1 = 5'd16;
    for (int i = 0; i < 16; i++) exp_q1.push_back({4'(i), ~32'(i)});
    start1 = 1;
    ticks(3);
    chk("full we active low", we1, 0);
    chk("full first addr", addr1, 0);
    chk("full first data", data1, 32'hFFFF_FFFF);
    wait_done(1, 40);
    chk("full end_out", end1, 1);
    chk("full we idle high", we1, 1);
    chk("full busy", busy1, 0);
    chk("full 16 writes", exp_q1.size(), 0);
    start1 = 0;
    ticks(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
